ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

Single-port AHB-Lite SRAM slave that sits directly downstream of the AHB master on the same bus. It accepts address phases (HADDR/HTRANS/HWRITE/HSIZE), completes the matching data phases with a programmable number of wait states, and returns HRDATA/HREADY/HRESP to the master. It supports byte, halfword and word transfers. Out-of-range, misaligned and oversize accesses get the standard two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 supported
- MEM_DEPTH, 256, memory size in 32-bit words; power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- WAIT_STATES, 0, wait cycles inserted per OKAY transfer, 0..15
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select from decoder; tie 1 in single-slave systems
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  000 byte, 001 half, 010 word
- HBURST  in  3  accepted, not used
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus-level ready; tie to HREADYOUT in single-slave systems
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  DATA_WIDTH  read data

## Operation
- Address phase is accepted when HSEL & HTRANS[1] & HREADY at a rising edge. The slave then latches the address, write flag and size, and runs the error check.
- Error check flags any of the following:
  - HSIZE > 010
  - HADDR misaligned to HSIZE
  - (HADDR − BASE_ADDR) ≥ 4·MEM_DEPTH, or HADDR < BASE_ADDR
- IDLE/BUSY, or HSEL=0 with HREADY=1, gives no transfer. The next cycle is an OKAY zero-wait cycle.
- FSM states:
  - ST_IDLE: no data phase pending.
  - ST_WAIT: counter counts down from WAIT_STATES.
  - ST_ERR1, ST_ERR2: the two ERROR response cycles.
- FSM transitions:
  - Accepted with error → ST_ERR1 → ST_ERR2.
  - Accepted OK, WAIT_STATES>0 → ST_WAIT.
  - Accepted OK, WAIT_STATES=0 → data phase completes in the next cycle.
- Write: on the completing edge of the data phase (HREADYOUT=1), the HWDATA lanes are written.
  - Byte enables are little-endian, taken from addr[1:0] and the latched size.
  - Byte: lane addr[1:0]. Half: lanes {addr[1],0}+1..0. Word: all lanes.
- Read: HRDATA = mem[word index] during the read data phase, full word on all lanes. The master selects the lanes.
- Errored transfers never write memory. HRDATA = 0 outside a read data phase.
- Pipelining: a new address phase may be accepted in the same cycle a data phase completes. Back-to-back write→read to the same word returns the new data.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=ST_IDLE, wait counter=0, latched control=0. Memory contents are not reset.
- OKAY latency from address acceptance: WAIT_STATES+1 cycles to completion. HREADYOUT is low for WAIT_STATES cycles, then high.
- ERROR response:
  - ST_ERR1: HREADYOUT=0, HRESP=1.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
  - HTRANS arriving during ST_ERR1 is not accepted, because HREADY=0.
- While HREADYOUT=0, address-phase inputs are ignored. The master must hold them.
- Reset asserted mid-transfer aborts the transfer immediately. A pending write is not performed.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE codes (BYTE/HALF/WORD)
  - HRESP codes (OKAY/ERROR)
  - the slave FSM state enum
- Sub-module ahb_sram_mem: MEM_DEPTH×32 array with 4-bit byte-write-enable, synchronous write and asynchronous read. The FSM, decode and lane logic stay in the top.

## Test plan
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10. Expect HREADYOUT=1 throughout and HRDATA=0xDEADBEEF in the read data phase.
- Byte write 0xAB @0x13 over the 0xDEADBEEF word, then word read @0x10. Expect 0xABADBEEF.
- WAIT_STATES=3: single read. Expect HREADYOUT low for exactly 3 cycles, then high with valid HRDATA.
- Read @0x400 with MEM_DEPTH=256, and a half write @0x11. Each gives ERROR with HREADYOUT 0 then 1, HRESP=1 for both cycles, and memory is unchanged.
- Back-to-back NONSEQ write @0x20 then SEQ read @0x20 with no IDLE between. The read returns the written data.
- Reset pulse during ST_WAIT of a write. Outputs go to reset values, and the target word is unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } slv_state_e;

   // Little-endian lane enables for an aligned transfer of the given size.
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << off;
         HSIZE_HALF: be = 4'b0011 << {off[1], 1'b0};
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array: synchronous byte-masked write, asynchronous read.
module ahb_sram_mem
   import ahb_pkg::*;
#(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [IDX_W-1:0]      idx_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address decode/error check, wait-state FSM and lane logic
// in front of a single-port word array.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           MEM_DEPTH   = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);

   localparam int unsigned           IDX_W = $clog2(MEM_DEPTH);
   localparam int unsigned           OFF_W = IDX_W + 2;
   localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);

   slv_state_e       state_q;
   logic [3:0]       cnt_q;
   logic [OFF_W-1:0] addr_q;
   logic             write_q;
   logic [2:0]       size_q;
   logic             dphase_q;
   logic             hreadyout_q;
   logic             hresp_q;

   logic [ADDR_WIDTH:0]   off_ext;
   logic                  accept;
   logic                  size_err;
   logic                  align_err;
   logic                  range_err;
   logic                  acc_err;
   logic                  we;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  unused_bits;

   assign unused_bits = ^{HBURST, HTRANS[0]};

   // Extra MSB catches HADDR below BASE_ADDR as a borrow.
   assign off_ext   = {1'b0, HADDR} - {1'b0, BASE_ADDR};
   assign accept    = HSEL & HTRANS[1] & HREADY;
   assign size_err  = HSIZE > HSIZE_WORD;
   assign align_err = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
   assign range_err = off_ext[ADDR_WIDTH] | (off_ext[ADDR_WIDTH-1:0] >= LIMIT);
   assign acc_err   = size_err | align_err | range_err;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         size_q      <= '0;
         dphase_q    <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         case (state_q)
            ST_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q     <= ST_IDLE;
                  hreadyout_q <= 1'b1;
               end
            end
            ST_ERR1: begin
               state_q     <= ST_ERR2;
               hreadyout_q <= 1'b1;
            end
            default: begin
               // Any pending data phase completes on this edge; a new address
               // phase may be taken in the same cycle.
               state_q     <= ST_IDLE;
               hreadyout_q <= 1'b1;
               hresp_q     <= HRESP_OKAY;
               dphase_q    <= 1'b0;
               if (accept) begin
                  addr_q  <= off_ext[OFF_W-1:0];
                  write_q <= HWRITE;
                  size_q  <= HSIZE;
                  if (acc_err) begin
                     state_q     <= ST_ERR1;
                     hreadyout_q <= 1'b0;
                     hresp_q     <= HRESP_ERROR;
                  end else begin
                     dphase_q <= 1'b1;
                     if (WAIT_STATES != 0) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= 4'(WAIT_STATES);
                        hreadyout_q <= 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign we = dphase_q & write_q & hreadyout_q;

   ahb_sram_mem #(
      .DEPTH      (MEM_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk_i   (HCLK),
      .we_i    (we),
      .be_i    (byte_en(size_q, addr_q[1:0])),
      .idx_i   (addr_q[OFF_W-1:2]),
      .wdata_i (HWDATA),
      .rdata_o (rdata)
   );

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = (dphase_q && !write_q) ? rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance share one bus,
// selected by dsel, checked against a byte-lane array model.
module tb_ahb_sram_slave;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        hsel = 1'b0;
   logic        dsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b000;
   logic [2:0]  hburst = 3'b000;
   logic        rdy0, rdy1, resp0, resp1;
   logic [31:0] rd0, rd1;
   logic        hsel0, hsel1;
   logic        rdy_m, resp_m;
   logic [31:0] rd_m;

   int total = 0;
   int bad = 0;
   logic [31:0] mdl [2][256];

   always #5 HCLK = ~HCLK;

   assign hsel0  = hsel & ~dsel;
   assign hsel1  = hsel & dsel;
   assign rdy_m  = dsel ? rdy1 : rdy0;
   assign resp_m = dsel ? resp1 : resp0;
   assign rd_m   = dsel ? rd1 : rd0;

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
                    .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
      .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
                    .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
      .HREADY(rdy1), .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1));

   function automatic int ws_of(input logic d);
      return d ? 3 : 0;
   endfunction

   function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz);
      if (sz > 3'd2) return 1'b1;
      if ((a % (32'd1 << sz)) != 0) return 1'b1;
      if (a >= 32'd1024) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_write(input logic d, input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] wd);
      int n, off;
      n = 1 << sz;
      off = int'(a % 4);
      for (int b = 0; b < 4; b++)
         if (b >= off && b < off + n) mdl[d][a / 4][8*b +: 8] = wd[8*b +: 8];
   endtask

   // Single transfer on the selected instance; returns what the bus showed.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output int lows, output logic rf,
                       output logic rl, output logic [31:0] rd);
      @(negedge HCLK);
      hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
      hburst = 3'($urandom_range(0, 7));
      @(posedge HCLK);
      @(negedge HCLK);
      hsel = 1'b0; htrans = 2'b00; hwdata = wd; haddr = $urandom;
      lows = 0;
      rf = resp_m;
      while (rdy_m !== 1'b1 && lows < 40) begin
         lows++;
         @(negedge HCLK);
      end
      rl = resp_m;
      rd = rd_m;
      @(posedge HCLK);
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      total += 6;
      if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_rdy0 got=%b exp=1", rdy0); end
      if (resp0 !== 1'b0) begin bad++; $display("FAIL reset_resp0 got=%b exp=0", resp0); end
      if (rd0 !== 32'h0) begin bad++; $display("FAIL reset_rd0 got=%h exp=0", rd0); end
      if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_rdy1 got=%b exp=1", rdy1); end
      if (resp1 !== 1'b0) begin bad++; $display("FAIL reset_resp1 got=%b exp=0", resp1); end
      if (rd1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h exp=0", rd1); end
      HRESETn = 1'b1;
   endtask

   task automatic test_fill();
      int lows; logic rf, rl; logic [31:0] rd, wd;
      for (int d = 0; d < 2; d++) begin
         dsel = d[0];
         for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            xfer(1'b1, 32'(i * 4), 3'd2, wd, lows, rf, rl, rd);
            model_write(d[0], 32'(i * 4), 3'd2, wd);
            total++;
            if (lows !== ws_of(d[0]) || rl !== 1'b0) begin
               bad++;
               $display("FAIL fill d%0d w%0d lows=%0d resp=%b exp lows=%0d resp=0", d, i, lows, rl, ws_of(d[0]));
            end
         end
      end
   endtask

   task automatic test_word_byte();
      int lows; logic rf, rl; logic [31:0] rd;
      dsel = 1'b0;
      xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, lows, rf, rl, rd);
      model_write(1'b0, 32'h10, 3'd2, 32'hDEADBEEF);
      total++;
      if (lows !== 0) begin bad++; $display("FAIL wr_ready got lows=%0d exp=0", lows); end
      xfer(1'b0, 32'h10, 3'd2, 32'h0, lows, rf, rl, rd);
      total += 2;
      if (lows !== 0) begin bad++; $display("FAIL rd_ready got lows=%0d exp=0", lows); end
      if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_read got=%h exp=deadbeef", rd); end
      xfer(1'b1, 32'h13, 3'd0, {4{8'hAB}}, lows, rf, rl, rd);
      model_write(1'b0, 32'h13, 3'd0, {4{8'hAB}});
      xfer(1'b0, 32'h10, 3'd2, 32'h0, lows, rf, rl, rd);
      total++;
      if (rd !== 32'hABADBEEF) begin bad++; $display("FAIL byte_merge got=%h exp=abadbeef", rd); end
   endtask

   task automatic test_wait_states();
      int lows; logic rf, rl; logic [31:0] rd, wd;
      dsel = 1'b1;
      wd = $urandom;
      xfer(1'b1, 32'h44, 3'd2, wd, lows, rf, rl, rd);
      model_write(1'b1, 32'h44, 3'd2, wd);
      xfer(1'b0, 32'h44, 3'd2, 32'h0, lows, rf, rl, rd);
      total += 3;
      if (lows !== 3) begin bad++; $display("FAIL ws_low_cycles got=%0d exp=3", lows); end
      if (rl !== 1'b0) begin bad++; $display("FAIL ws_resp got=%b exp=0", rl); end
      if (rd !== wd) begin bad++; $display("FAIL ws_rdata got=%h exp=%h", rd, wd); end
   endtask

   task automatic test_errors();
      int lows; logic rf, rl; logic [31:0] rd;
      logic        tw [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] ta [4] = '{32'h400, 32'h11, 32'h10, 32'h12};
      logic [2:0]  ts [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
      for (int d = 0; d < 2; d++) begin
         dsel = d[0];
         for (int k = 0; k < 4; k++) begin
            xfer(tw[k], ta[k], ts[k], 32'hFFFF_FFFF, lows, rf, rl, rd);
            total += 4;
            if (lows !== 1) begin bad++; $display("FAIL err%0d_%0d low got=%0d exp=1", d, k, lows); end
            if (rf !== 1'b1) begin bad++; $display("FAIL err%0d_%0d resp1 got=%b exp=1", d, k, rf); end
            if (rl !== 1'b1) begin bad++; $display("FAIL err%0d_%0d resp2 got=%b exp=1", d, k, rl); end
            if (rd !== 32'h0) begin bad++; $display("FAIL err%0d_%0d rdata got=%h exp=0", d, k, rd); end
         end
         xfer(1'b0, 32'h10, 3'd2, 32'h0, lows, rf, rl, rd);
         total++;
         if (rd !== mdl[d][4]) begin bad++; $display("FAIL err%0d_unchanged got=%h exp=%h", d, rd, mdl[d][4]); end
      end
   endtask

   task automatic test_random();
      int lows; logic rf, rl; logic [31:0] rd, a, wd, exp_rd; logic [2:0] sz; logic w, e;
      int r;
      for (int i = 0; i < 300; i++) begin
         dsel = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         if (r == 0) a = 32'h400 + $urandom_range(0, 255);
         else if (r == 1) a = $urandom;
         else a = $urandom_range(0, 255);
         sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         wd = $urandom;
         e = exp_err(a, sz);
         exp_rd = (!w && !e) ? mdl[dsel][a / 4] : 32'h0;
         xfer(w, a, sz, wd, lows, rf, rl, rd);
         if (w && !e) model_write(dsel, a, sz, wd);
         total++;
         if (lows !== (e ? 1 : ws_of(dsel)) || rf !== e || rl !== e || rd !== exp_rd) begin
            bad++;
            $display("FAIL rand%0d d%0d w=%b a=%h sz=%0d got lows=%0d rf=%b rl=%b rd=%h exp lows=%0d resp=%b rd=%h",
                     i, dsel, w, a, sz, lows, rf, rl, rd, e ? 1 : ws_of(dsel), e, exp_rd);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n1, n2; logic [31:0] wd, rd;
      for (int d = 0; d < 2; d++) begin
         dsel = d[0];
         wd = $urandom;
         @(negedge HCLK);
         hsel = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
         @(posedge HCLK);
         @(negedge HCLK);
         hwdata = wd; htrans = 2'b11; hwrite = 1'b0;
         n1 = 0;
         while (rdy_m !== 1'b1 && n1 < 40) begin n1++; @(negedge HCLK); end
         @(posedge HCLK);
         @(negedge HCLK);
         hsel = 1'b0; htrans = 2'b00; hwdata = $urandom;
         n2 = 0;
         while (rdy_m !== 1'b1 && n2 < 40) begin n2++; @(negedge HCLK); end
         rd = rd_m;
         @(posedge HCLK);
         model_write(d[0], 32'h20, 3'd2, wd);
         total += 3;
         if (n1 !== ws_of(d[0])) begin bad++; $display("FAIL b2b%0d_wr_wait got=%0d exp=%0d", d, n1, ws_of(d[0])); end
         if (n2 !== ws_of(d[0])) begin bad++; $display("FAIL b2b%0d_rd_wait got=%0d exp=%0d", d, n2, ws_of(d[0])); end
         if (rd !== wd) begin bad++; $display("FAIL b2b%0d_rdata got=%h exp=%h", d, rd, wd); end
      end
   endtask

   task automatic test_reset_mid();
      int lows; logic rf, rl; logic [31:0] rd, old;
      dsel = 1'b1;
      old = mdl[1][12];
      @(negedge HCLK);
      hsel = 1'b1; haddr = 32'h30; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(posedge HCLK);
      @(negedge HCLK);
      hsel = 1'b0; htrans = 2'b00; hwdata = ~old;
      total++;
      if (rdy1 !== 1'b0) begin bad++; $display("FAIL rst_mid_inwait got=%b exp=0", rdy1); end
      @(negedge HCLK);
      HRESETn = 1'b0;
      #1;
      total += 3;
      if (rdy1 !== 1'b1) begin bad++; $display("FAIL rst_mid_rdy got=%b exp=1", rdy1); end
      if (resp1 !== 1'b0) begin bad++; $display("FAIL rst_mid_resp got=%b exp=0", resp1); end
      if (rd1 !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata got=%h exp=0", rd1); end
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      xfer(1'b0, 32'h30, 3'd2, 32'h0, lows, rf, rl, rd);
      total += 2;
      if (lows !== 3) begin bad++; $display("FAIL rst_mid_after_wait got=%0d exp=3", lows); end
      if (rd !== old) begin bad++; $display("FAIL rst_mid_word got=%h exp=%h", rd, old); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_word_byte();
      test_wait_states();
      test_errors();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
